// File: rtl/reg_dump_reader.sv
// reg_dump_reader: walks an inclusive register address range through one
// read port of the register file and streams each (index, data) pair out
// on a valid/ready interface. One beat per two cycles at most.
module reg_dump_reader #(
    parameter int W = 8,
    parameter int D = 3
) (
    input  logic         CLK,
    input  logic         Reset_n,
    input  logic         Dump_start,
    input  logic [D-1:0] Dump_lo,
    input  logic [D-1:0] Dump_hi,
    input  logic         Dump_abort,
    output logic         Dump_busy,
    output logic         Dump_done,
    output logic [D-1:0] Reg_read_address,
    input  logic [W-1:0] Reg_read_data,
    output logic         Out_valid,
    input  logic         Out_ready,
    output logic [D-1:0] Out_index,
    output logic [W-1:0] Out_data
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SEND  = 2'd2,
        DONE  = 2'd3
    } state_e;

    state_e         state_q, state_d;
    logic [D-1:0]   cnt_q, cnt_d;
    logic [D-1:0]   hi_q, hi_d;
    logic           valid_q, valid_d;
    logic [D-1:0]   index_q, index_d;
    logic [W-1:0]   data_q, data_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;

    // Next-state and registered-output computation.
    // The counter itself holds the latched low bound; only hi needs its own flop.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        valid_d = valid_q;
        index_d = index_q;
        data_d  = data_q;

        unique case (state_q)
            IDLE: begin
                if (Dump_start) begin
                    hi_d    = Dump_hi;
                    cnt_d   = Dump_lo;
                    state_d = (Dump_lo <= Dump_hi) ? FETCH : DONE;
                end
            end
            FETCH: begin
                data_d  = Reg_read_data;
                index_d = cnt_q;
                valid_d = 1'b1;
                state_d = SEND;
            end
            SEND: begin
                if (valid_q && Out_ready) begin
                    valid_d = 1'b0;
                    if (cnt_q == hi_q) begin
                        state_d = DONE;
                    end else begin
                        cnt_d   = cnt_q + D'(1);
                        state_d = FETCH;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Abort overrides any handshake or counter step taken above.
        if (Dump_abort && (state_q != IDLE)) begin
            state_d = IDLE;
            valid_d = 1'b0;
            cnt_d   = cnt_q;
        end

        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    // State and output registers, cleared asynchronously.
    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            valid_q <= 1'b0;
            index_q <= '0;
            data_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            valid_q <= valid_d;
            index_q <= index_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign Reg_read_address = cnt_q;
    assign Out_valid        = valid_q;
    assign Out_index        = index_q;
    assign Out_data         = data_q;
    assign Dump_busy        = busy_q;
    assign Dump_done        = done_q;

endmodule

// File: tb/tb_reg_dump_reader.sv
// Bench for reg_dump_reader: directed dumps against a small register-file
// model, with a scoreboard queue drained by an independent monitor.
module tb_reg_dump_reader;

    localparam int W = 8;
    localparam int D = 3;

    logic         CLK;
    logic         Reset_n;
    logic         Dump_start;
    logic [D-1:0] Dump_lo;
    logic [D-1:0] Dump_hi;
    logic         Dump_abort;
    logic         Dump_busy;
    logic         Dump_done;
    logic [D-1:0] Reg_read_address;
    logic [W-1:0] Reg_read_data;
    logic         Out_valid;
    logic         Out_ready;
    logic [D-1:0] Out_index;
    logic [W-1:0] Out_data;

    logic [W-1:0] regs [8];
    assign Reg_read_data = regs[Reg_read_address];

    reg_dump_reader #(.W(W), .D(D)) dut (
        .CLK              (CLK),
        .Reset_n          (Reset_n),
        .Dump_start       (Dump_start),
        .Dump_lo          (Dump_lo),
        .Dump_hi          (Dump_hi),
        .Dump_abort       (Dump_abort),
        .Dump_busy        (Dump_busy),
        .Dump_done        (Dump_done),
        .Reg_read_address (Reg_read_address),
        .Reg_read_data    (Reg_read_data),
        .Out_valid        (Out_valid),
        .Out_ready        (Out_ready),
        .Out_index        (Out_index),
        .Out_data         (Out_data)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int checks   = 0;
    int errors   = 0;
    int done_cnt = 0;
    int cyc      = 0;
    int start_cyc = 0;
    bit bp_mode  = 1'b0;

    logic [D+W-1:0] sb [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
        cyc++;
    endtask

    task automatic push(input logic [D-1:0] idx, input logic [W-1:0] dat);
        sb.push_back({idx, dat});
    endtask

    task automatic do_start(input logic [D-1:0] lo, input logic [D-1:0] hi);
        Dump_lo    = lo;
        Dump_hi    = hi;
        Dump_start = 1'b1;
        tick();
        start_cyc  = cyc;
        Dump_start = 1'b0;
        chk("start_addr", 32'(Reg_read_address), 32'(lo));
        chk("start_busy", 32'(Dump_busy), 32'd1);
    endtask

    task automatic finish_test(input string name, input int exp_cycles, input int exp_done);
        int n = 0;
        while (Dump_busy && n < 300) begin
            tick();
            n++;
        end
        chk({name, "_cycles"}, 32'(cyc - start_cyc), 32'(exp_cycles));
        tick();
        chk({name, "_done_pulses"}, 32'(done_cnt), 32'(exp_done));
        chk({name, "_sb_left"}, 32'(sb.size()), 32'd0);
        sb.delete();
        done_cnt = 0;
    endtask

    task automatic wait_beat(input logic [D-1:0] idx);
        int n = 0;
        while (!(Out_valid && Out_index == idx) && n < 60) begin
            tick();
            n++;
        end
        chk("wait_beat", 32'(Out_valid && Out_index == idx), 32'd1);
    endtask

    // Consumer: ready held high, or 0,0,1 per beat in backpressure mode.
    initial begin
        int wcnt = 0;
        Out_ready = 1'b0;
        forever begin
            @(posedge CLK);
            #1;
            if (bp_mode) begin
                if (Out_valid) begin
                    wcnt++;
                    Out_ready = (wcnt >= 3);
                end else begin
                    wcnt = 0;
                    Out_ready = 1'b0;
                end
            end else begin
                wcnt = 0;
                Out_ready = 1'b1;
            end
        end
    end

    // Monitor: pops the scoreboard on each transferred beat, checks hold-stability.
    initial begin
        bit           armed = 1'b0;
        logic [D-1:0] h_idx;
        logic [W-1:0] h_dat;
        logic [D+W-1:0] e;
        forever begin
            @(negedge CLK);
            if (!Reset_n) begin
                armed = 1'b0;
            end else begin
                if (Dump_done) done_cnt++;
                if (armed && Out_valid) begin
                    chk("hold_index", 32'(Out_index), 32'(h_idx));
                    chk("hold_data", 32'(Out_data), 32'(h_dat));
                end
                armed = Out_valid && !Out_ready && !Dump_abort;
                h_idx = Out_index;
                h_dat = Out_data;
                if (Out_valid && Out_ready && !Dump_abort) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_beat", 32'({Out_index, Out_data}), 32'h7ff);
                    end else begin
                        e = sb.pop_front();
                        chk("beat_index", 32'(Out_index), 32'(e[D+W-1:W]));
                        chk("beat_data", 32'(Out_data), 32'(e[W-1:0]));
                    end
                end
            end
        end
    end

    initial begin
        for (int k = 0; k < 8; k++) regs[k] = 8'hA0 + 8'(k);
        Reset_n    = 1'b0;
        Dump_start = 1'b0;
        Dump_abort = 1'b0;
        Dump_lo    = '0;
        Dump_hi    = '0;
        tick();
        tick();
        chk("rst_addr", 32'(Reg_read_address), 32'd0);
        chk("rst_valid", 32'(Out_valid), 32'd0);
        chk("rst_index", 32'(Out_index), 32'd0);
        chk("rst_data", 32'(Out_data), 32'd0);
        chk("rst_busy", 32'(Dump_busy), 32'd0);
        chk("rst_done", 32'(Dump_done), 32'd0);
        Reset_n = 1'b1;
        tick();
        tick();

        // Full dump 0..7, one beat every two cycles.
        for (int k = 0; k < 8; k++) push(3'(k), 8'hA0 + 8'(k));
        do_start(3'd0, 3'd7);
        finish_test("full", 17, 1);

        // Backpressure 2..4 with ready 0,0,1 per beat.
        bp_mode = 1'b1;
        push(3'd2, 8'hA2); push(3'd3, 8'hA3); push(3'd4, 8'hA4);
        do_start(3'd2, 3'd4);
        finish_test("bp", 13, 1);
        bp_mode = 1'b0;
        tick();

        // Single-entry range.
        push(3'd5, 8'hA5);
        do_start(3'd5, 3'd5);
        finish_test("single5", 3, 1);

        // Empty range: done in the cycle right after the start is taken.
        do_start(3'd6, 3'd1);
        chk("empty_done_now", 32'(Dump_done), 32'd1);
        chk("empty_valid", 32'(Out_valid), 32'd0);
        finish_test("empty", 1, 1);

        // Top address: no counter overflow.
        push(3'd7, 8'hA7);
        do_start(3'd7, 3'd7);
        finish_test("top7", 3, 1);
        chk("top7_addr_held", 32'(Reg_read_address), 32'd7);

        // Abort during SEND of index 3 with ready high.
        push(3'd0, 8'hA0); push(3'd1, 8'hA1); push(3'd2, 8'hA2);
        do_start(3'd0, 3'd7);
        wait_beat(3'd3);
        Dump_abort = 1'b1;
        tick();
        Dump_abort = 1'b0;
        chk("abort_valid", 32'(Out_valid), 32'd0);
        chk("abort_busy", 32'(Dump_busy), 32'd0);
        chk("abort_done", 32'(Dump_done), 32'd0);
        tick();
        tick();
        chk("abort_done_pulses", 32'(done_cnt), 32'd0);
        chk("abort_sb_left", 32'(sb.size()), 32'd0);
        sb.delete();
        done_cnt = 0;

        // Abort while idle does nothing; start together with abort is taken.
        Dump_abort = 1'b1;
        tick();
        chk("idle_abort_busy", 32'(Dump_busy), 32'd0);
        push(3'd1, 8'hA1);
        do_start(3'd1, 3'd1);
        Dump_abort = 1'b0;
        finish_test("start_abort", 3, 1);

        // Restart mid-dump is ignored.
        push(3'd2, 8'hA2); push(3'd3, 8'hA3);
        do_start(3'd2, 3'd3);
        tick();
        Dump_lo = 3'd0; Dump_hi = 3'd0; Dump_start = 1'b1;
        tick();
        Dump_start = 1'b0;
        finish_test("restart", 5, 1);

        // Coherency: write before FETCH of 4 is seen.
        push(3'd3, 8'hA3); push(3'd4, 8'h55); push(3'd5, 8'hA5);
        do_start(3'd3, 3'd5);
        tick();
        regs[4] = 8'h55;
        finish_test("coh_before", 7, 1);
        regs[4] = 8'hA4;

        // Coherency: write after FETCH of 4 is not seen.
        push(3'd3, 8'hA3); push(3'd4, 8'hA4); push(3'd5, 8'hA5);
        do_start(3'd3, 3'd5);
        tick(); tick(); tick();
        regs[4] = 8'h55;
        finish_test("coh_after", 7, 1);
        regs[4] = 8'hA4;

        // Asynchronous reset during SEND, then a fresh dump.
        bp_mode = 1'b1;
        do_start(3'd0, 3'd3);
        wait_beat(3'd0);
        #2;
        Reset_n = 1'b0;
        #1;
        chk("arst_valid", 32'(Out_valid), 32'd0);
        chk("arst_index", 32'(Out_index), 32'd0);
        chk("arst_data", 32'(Out_data), 32'd0);
        chk("arst_busy", 32'(Dump_busy), 32'd0);
        chk("arst_addr", 32'(Reg_read_address), 32'd0);
        chk("arst_done", 32'(Dump_done), 32'd0);
        tick();
        Reset_n = 1'b1;
        bp_mode = 1'b0;
        sb.delete();
        done_cnt = 0;
        tick();
        tick();
        push(3'd5, 8'hA5); push(3'd6, 8'hA6);
        do_start(3'd5, 3'd6);
        finish_test("post_rst", 5, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
